// File: rtl/mac_pkg.sv
// Shared MAC tile definitions: IEEE flag bit positions, packer FSM states, converter mode encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_pkg;

    // Bit positions inside a {NV,DZ,OF,UF,NX} flag vector
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef logic [4:0] fflags_t;

    // EMPTY: no FP16 half is held; HALF: first FP16 of a pair is waiting for its partner
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    // Same encoding as the FP32->FP16 converter's mode select
    localparam logic MODE_FP32 = 1'b1;
    localparam logic MODE_FP16 = 1'b0;

endpackage

// File: rtl/mac_result_packer.sv
// Packs converter results into 32-bit writeback words: FP16 pairs {second,first}, FP32 passthrough, sticky flags.
// Latency: 1 cycle from the beat that completes a word to out_valid; full throughput with out_ready=1.
// Backpressure: single output slot; in_ready drops while the slot is occupied and not being drained,
//   and for an FP32 beat while an FP16 half is held (the half is flushed first, FP32 accepted later).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           upstream element handshake
//   in_data, in_mode, in_last   element (FP16 in [15:0] when in_mode=0), mode, row end
//   in_flags                    {NV,DZ,OF,UF,NX} of the element
//   out_valid/out_ready         downstream word handshake
//   out_data, out_mask          packed word, valid halves (11 full, 01 low only)
//   out_last, out_flags         row end, OR of flags of the elements in the word
//   fflags_o, fflags_clr        sticky flags of all accepted elements, clear
//   elem_cnt_o                  accepted-element counter (wraps)
module mac_result_packer
    import mac_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_mode,
    input  logic             in_last,
    input  logic [4:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_mask,
    output logic             out_last,
    output logic [4:0]       out_flags,
    output logic [4:0]       fflags_o,
    input  logic             fflags_clr,
    output logic [CNT_W-1:0] elem_cnt_o
);

    pack_state_e state_q;
    pack_state_e state_d;
    logic [15:0] half_q;
    fflags_t     half_flags_q;

    logic        slot_free;
    logic        fp32_blocked;
    logic        accept;
    logic        flush;
    logic        capture_half;

    logic        load;
    logic [31:0] load_data;
    logic [1:0]  load_mask;
    logic        load_last;
    fflags_t     load_flags;

    // The slot can take a new word if it is empty or being drained this cycle
    assign slot_free    = !out_valid || out_ready;
    // An FP32 beat cannot share a word with a held FP16 half, so it waits for the flush
    assign fp32_blocked = (state_q == HALF) && in_valid && (in_mode == MODE_FP32);
    assign in_ready     = slot_free && !fp32_blocked;
    assign accept       = in_valid && in_ready;
    assign flush        = slot_free && fp32_blocked;

    always_comb begin
        state_d      = state_q;
        capture_half = 1'b0;
        load         = 1'b0;
        load_data    = '0;
        load_mask    = '0;
        load_last    = 1'b0;
        load_flags   = '0;

        if (accept) begin
            if (in_mode == MODE_FP32) begin
                // Only reachable from EMPTY: HALF blocks FP32 beats
                load       = 1'b1;
                load_data  = in_data;
                load_mask  = 2'b11;
                load_last  = in_last;
                load_flags = in_flags;
            end else if (state_q == HALF) begin
                load       = 1'b1;
                load_data  = {in_data[15:0], half_q};
                load_mask  = 2'b11;
                load_last  = in_last;
                load_flags = half_flags_q | in_flags;
                state_d    = EMPTY;
            end else if (in_last) begin
                // Odd element at row end goes out alone in the low half
                load       = 1'b1;
                load_data  = {16'h0000, in_data[15:0]};
                load_mask  = 2'b01;
                load_last  = 1'b1;
                load_flags = in_flags;
            end else begin
                capture_half = 1'b1;
                state_d      = HALF;
            end
        end else if (flush) begin
            // Held half is emitted on its own; the row continues with the FP32 beat
            load       = 1'b1;
            load_data  = {16'h0000, half_q};
            load_mask  = 2'b01;
            load_last  = 1'b0;
            load_flags = half_flags_q;
            state_d    = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            half_q       <= '0;
            half_flags_q <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_mask     <= '0;
            out_last     <= 1'b0;
            out_flags    <= '0;
            fflags_o     <= '0;
            elem_cnt_o   <= '0;
        end else begin
            state_q <= state_d;

            if (capture_half) begin
                half_q       <= in_data[15:0];
                half_flags_q <= in_flags;
            end

            // out_* only change on a load, so they stay stable while stalled
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_mask  <= load_mask;
                out_last  <= load_last;
                out_flags <= load_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A clear coinciding with an accept keeps the new element's flags
            fflags_o <= (fflags_clr ? 5'b00000 : fflags_o) | (accept ? in_flags : 5'b00000);

            if (accept) begin
                elem_cnt_o <= elem_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_result_packer.sv
// Self-checking bench for mac_result_packer: directed scenarios followed by random traffic,
// all compared each cycle against a word-level reference model.
// Uses a narrow element counter so the wrap is exercised within the run.
module tb_mac_result_packer;
    import mac_pkg::*;

    localparam int TB_CNT_W = 4;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mask;
        logic        last;
        logic [4:0]  flags;
    } word_t;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  f;
    } half_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [31:0]         in_data = '0;
    logic                in_mode = 1'b0;
    logic                in_last = 1'b0;
    logic [4:0]          in_flags = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [31:0]         out_data;
    logic [1:0]          out_mask;
    logic                out_last;
    logic [4:0]          out_flags;
    logic [4:0]          fflags_o;
    logic                fflags_clr = 1'b0;
    logic [TB_CNT_W-1:0] elem_cnt_o;

    mac_result_packer #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_last    (in_last),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mask   (out_mask),
        .out_last   (out_last),
        .out_flags  (out_flags),
        .fflags_o   (fflags_o),
        .fflags_clr (fflags_clr),
        .elem_cnt_o (elem_cnt_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending output word, held FP16 halves, counter, sticky flags
    logic  m_pend = 1'b0;
    word_t m_word;
    half_t m_held[$];
    int    m_cnt = 0;
    logic [4:0] m_sticky = '0;

    // Words seen leaving the DUT (valid && ready), for the directed scenarios
    word_t hs_log[$];

    // DUT outputs captured at the last checked cycle
    logic        obs_rdy;
    logic        obs_valid;
    logic [31:0] obs_data;
    logic [4:0]  obs_fflags;
    logic [TB_CNT_W-1:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the model on the falling edge, then advance the model to the next rising edge
    task automatic check_and_model();
        logic  exp_free, hold_fp32, exp_rdy, acc, ld;
        word_t w;
        half_t h;

        obs_rdy    = in_ready;
        obs_valid  = out_valid;
        obs_data   = out_data;
        obs_fflags = fflags_o;
        obs_cnt    = elem_cnt_o;

        exp_free  = !m_pend || out_ready;
        hold_fp32 = (m_held.size() != 0) && in_valid && in_mode;
        exp_rdy   = exp_free && !hold_fp32;
        acc       = in_valid && exp_rdy;

        chk("out_valid", out_valid, m_pend);
        chk("in_ready", in_ready, exp_rdy);
        chk("fflags_o", fflags_o, m_sticky);
        chk("elem_cnt_o", elem_cnt_o, m_cnt);
        if (m_pend) begin
            chk("out_data", out_data, m_word.data);
            chk("out_mask", out_mask, m_word.mask);
            chk("out_last", out_last, m_word.last);
            chk("out_flags", out_flags, m_word.flags);
            if (out_ready) begin
                w = '{data: out_data, mask: out_mask, last: out_last, flags: out_flags};
                hs_log.push_back(w);
            end
        end

        if (!rst_n) begin
            m_pend   = 1'b0;
            m_held.delete();
            m_cnt    = 0;
            m_sticky = '0;
        end else begin
            ld = 1'b0;
            w  = '{data: 32'h0, mask: 2'b00, last: 1'b0, flags: 5'h0};
            if (fflags_clr) m_sticky = '0;
            if (acc) begin
                m_cnt    = (m_cnt + 1) % (1 << TB_CNT_W);
                m_sticky = m_sticky | in_flags;
                if (in_mode) begin
                    ld = 1'b1;
                    w  = '{data: in_data, mask: 2'b11, last: in_last, flags: in_flags};
                end else if (m_held.size() != 0) begin
                    h  = m_held.pop_front();
                    ld = 1'b1;
                    w  = '{data: {in_data[15:0], h.d}, mask: 2'b11, last: in_last, flags: h.f | in_flags};
                end else if (in_last) begin
                    ld = 1'b1;
                    w  = '{data: {16'h0, in_data[15:0]}, mask: 2'b01, last: 1'b1, flags: in_flags};
                end else begin
                    h = '{d: in_data[15:0], f: in_flags};
                    m_held.push_back(h);
                end
            end else if (hold_fp32 && exp_free) begin
                h  = m_held.pop_front();
                ld = 1'b1;
                w  = '{data: {16'h0, h.d}, mask: 2'b01, last: 1'b0, flags: h.f};
            end
            if (ld) begin
                m_pend = 1'b1;
                m_word = w;
            end else if (out_ready) begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic m, input logic l,
                        input logic [4:0] f, input logic ordy, input logic clr);
        in_valid   = v;
        in_data    = d;
        in_mode    = m;
        in_last    = l;
        in_flags   = f;
        out_ready  = ordy;
        fflags_clr = clr;
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, MODE_FP16, 1'b0, 5'h0, ordy, 1'b0);
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] d,
                            input logic [1:0] mk, input logic l, input logic [4:0] f);
        if (idx < hs_log.size()) begin
            chk({tag, " data"}, hs_log[idx].data, d);
            chk({tag, " mask"}, hs_log[idx].mask, mk);
            chk({tag, " last"}, hs_log[idx].last, l);
            chk({tag, " flags"}, hs_log[idx].flags, f);
        end else begin
            chk({tag, " present"}, 32'(hs_log.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int base_cnt;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_mask", out_mask, 2'b00);
        chk("rst out_last", out_last, 1'b0);
        chk("rst out_flags", out_flags, 5'h0);
        chk("rst fflags_o", fflags_o, 5'h0);
        chk("rst elem_cnt_o", elem_cnt_o, 0);
        @(posedge clk);
        #1;

        // Four FP16 beats pair into two words, second closes the row
        hs_log.delete();
        step(1, 32'h0000_3C00, MODE_FP16, 0, 5'h00, 1, 0);
        step(1, 32'hDEAD_4000, MODE_FP16, 0, 5'h00, 1, 0);
        step(1, 32'h0000_4200, MODE_FP16, 0, 5'h00, 1, 0);
        step(1, 32'h0000_4400, MODE_FP16, 1, 5'h00, 1, 0);
        idle(1);
        idle(1);
        chk("t1 words", 32'(hs_log.size()), 2);
        chk_word("t1 w0", 0, 32'h4000_3C00, 2'b11, 0, 5'h00);
        chk_word("t1 w1", 1, 32'h4400_4200, 2'b11, 1, 5'h00);

        // FP32 beat behind a held half: half flushed alone, FP32 taken on the next cycle
        hs_log.delete();
        step(1, 32'h0000_4000, MODE_FP16, 0, 5'h02, 1, 0);
        step(1, 32'h3F80_0000, MODE_FP32, 0, 5'h00, 1, 0);
        chk("t2 in_ready on flush", obs_rdy, 1'b0);
        step(1, 32'h3F80_0000, MODE_FP32, 0, 5'h00, 1, 0);
        chk("t2 in_ready after flush", obs_rdy, 1'b1);
        idle(1);
        idle(1);
        chk("t2 words", 32'(hs_log.size()), 2);
        chk_word("t2 w0", 0, 32'h0000_4000, 2'b01, 0, 5'h02);
        chk_word("t2 w1", 1, 32'h3F80_0000, 2'b11, 0, 5'h00);

        // Lone FP16 with last carries its flags in a low-half word
        hs_log.delete();
        step(1, 32'h0000_7C00, MODE_FP16, 1, (5'b1 << FLG_OF) | (5'b1 << FLG_NX), 1, 0);
        idle(1);
        idle(1);
        chk("t3 words", 32'(hs_log.size()), 1);
        chk_word("t3 w0", 0, 32'h0000_7C00, 2'b01, 1, 5'b00101);

        // Downstream stall while pairing: word held stable, nothing accepted, nothing lost
        hs_log.delete();
        base_cnt = m_cnt;
        step(1, 32'h0000_3C00, MODE_FP16, 0, 5'h00, 1, 0);
        step(1, 32'h0000_4000, MODE_FP16, 0, 5'h00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h0000_4200, MODE_FP16, 0, 5'h00, 0, 0);
            chk("t4 stall in_ready", obs_rdy, 1'b0);
            chk("t4 stall out_data", obs_data, 32'h4000_3C00);
        end
        step(1, 32'h0000_4200, MODE_FP16, 0, 5'h00, 1, 0);
        step(1, 32'h0000_4400, MODE_FP16, 1, 5'h00, 1, 0);
        idle(1);
        idle(1);
        chk("t4 count", obs_cnt, (base_cnt + 4) % (1 << TB_CNT_W));
        chk("t4 words", 32'(hs_log.size()), 2);
        chk_word("t4 w0", 0, 32'h4000_3C00, 2'b11, 0, 5'h00);
        chk_word("t4 w1", 1, 32'h4400_4200, 2'b11, 1, 5'h00);

        // Clear coinciding with an NV accept leaves only NV
        step(1, 32'h0000_0001, MODE_FP16, 1, 5'b00001, 1, 0);
        step(1, 32'h0000_0002, MODE_FP16, 1, 5'b1 << FLG_NV, 1, 1);
        idle(1);
        chk("t5 fflags", obs_fflags, 5'b10000);

        // Reset with a held half discards it and clears counters
        step(1, 32'h0000_AAAA, MODE_FP16, 0, 5'h08, 1, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        chk("t6 out_valid", obs_valid, 1'b0);
        chk("t6 fflags", obs_fflags, 5'h00);
        chk("t6 cnt", obs_cnt, 0);
        hs_log.delete();
        step(1, 32'h0000_1234, MODE_FP16, 1, 5'h00, 1, 0);
        idle(1);
        chk_word("t6 fresh", 0, 32'h0000_1234, 2'b01, 1, 5'h00);

        // Reset with a stalled output word drops it
        step(1, 32'h1111_2222, MODE_FP32, 0, 5'h00, 0, 0);
        idle(0);
        rst_n = 1'b0;
        idle(0);
        rst_n = 1'b1;
        idle(0);
        chk("t6b out_valid", obs_valid, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 9) < 7,
                 $urandom,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 4) == 0,
                 5'($urandom),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end
        rst_n = 1'b1;
        idle(1);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
